// File: rtl/mem_issue_skid_pkg.sv
// Shared definitions for the memory issue skid stage and neighbouring stages.
// Holds the default widths, the stored entry layout, FIFO sizing helpers and
// the wrap-aware flush-range test used by every stage that honours a flush.
package mem_issue_skid_pkg;

  localparam int MEM_NUM_LANES  = 2;
  localparam int MEM_SKID_DEPTH = 2;
  localparam int MEM_AL_PTR_W   = 6;
  localparam int MEM_IQ_PTR_W   = 5;
  localparam int MEM_PAYLOAD_W  = 96;

  // One skid slot. valid is cleared by a selective flush; the slot still
  // occupies the FIFO until it reaches the head and is squashed.
  typedef struct packed {
    logic                     valid;
    logic                     replay;
    logic [MEM_AL_PTR_W-1:0]  al_ptr;
    logic [MEM_PAYLOAD_W-1:0] payload;
  } entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Range is [head, tail) modulo 2^AL_PTR_W; head==tail is empty unless
  // flush_all is set.
  function automatic logic in_range(
    input logic                    flush_req,
    input logic                    flush_all,
    input logic [MEM_AL_PTR_W-1:0] head,
    input logic [MEM_AL_PTR_W-1:0] tail,
    input logic [MEM_AL_PTR_W-1:0] p
  );
    logic hit;
    if (head <= tail) hit = (p >= head) && (p < tail);
    else              hit = (p >= head) || (p < tail);
    return flush_req && (flush_all || hit);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/mem_issue_skid_stage_if.sv
// Handshake/data bundle between scheduler select, the skid stage and
// register read. master = surrounding pipeline (drives in_*, replay_*,
// flush/clear, out_ready); slave = the skid stage.
interface mem_issue_skid_stage_if
  import mem_issue_skid_pkg::*;
#(
  parameter int NUM_LANES = MEM_NUM_LANES,
  parameter int AL_PTR_W  = MEM_AL_PTR_W,
  parameter int IQ_PTR_W  = MEM_IQ_PTR_W,
  parameter int PAYLOAD_W = MEM_PAYLOAD_W
);
  logic [NUM_LANES-1:0]           in_valid;
  logic [NUM_LANES*PAYLOAD_W-1:0] in_payload;
  logic [NUM_LANES*AL_PTR_W-1:0]  in_al_ptr;
  logic [NUM_LANES*IQ_PTR_W-1:0]  in_iq_ptr;
  logic [NUM_LANES-1:0]           in_ready;
  logic                           replay;
  logic [NUM_LANES-1:0]           replay_valid;
  logic [NUM_LANES*PAYLOAD_W-1:0] replay_payload;
  logic [NUM_LANES*AL_PTR_W-1:0]  replay_al_ptr;
  logic                           clear;
  logic                           flush_req;
  logic                           flush_all;
  logic [AL_PTR_W-1:0]            flush_head;
  logic [AL_PTR_W-1:0]            flush_tail;
  logic [NUM_LANES-1:0]           iq_issue;
  logic [NUM_LANES*IQ_PTR_W-1:0]  iq_issue_ptr;
  logic [NUM_LANES-1:0]           out_valid;
  logic [NUM_LANES*PAYLOAD_W-1:0] out_payload;
  logic [NUM_LANES*AL_PTR_W-1:0]  out_al_ptr;
  logic [NUM_LANES-1:0]           out_replay;
  logic [NUM_LANES-1:0]           out_ready;

  modport master (
    output in_valid, in_payload, in_al_ptr, in_iq_ptr,
    output replay, replay_valid, replay_payload, replay_al_ptr,
    output clear, flush_req, flush_all, flush_head, flush_tail, out_ready,
    input  in_ready, iq_issue, iq_issue_ptr,
    input  out_valid, out_payload, out_al_ptr, out_replay
  );

  modport slave (
    input  in_valid, in_payload, in_al_ptr, in_iq_ptr,
    input  replay, replay_valid, replay_payload, replay_al_ptr,
    input  clear, flush_req, flush_all, flush_head, flush_tail, out_ready,
    output in_ready, iq_issue, iq_issue_ptr,
    output out_valid, out_payload, out_al_ptr, out_replay
  );
endinterface

// File: rtl/mem_issue_skid_fifo.sv
// One-lane skid FIFO with per-entry valid kill for selective flush.
// Latency: enqueue into empty -> out_vld_o next cycle, no bypass.
// Backpressure: in_rdy_o low only when full and the head is not leaving.
// Ports: clk/rst, enq_i + enq_entry_i (write), out_vld_o/out_rdy_i (read),
// head fields, clear_i and flush_* (kill). Optional kill_cnt_o when
// MEM_ISSUE_SKID_PERF_EN is defined.
module mem_issue_skid_fifo
  import mem_issue_skid_pkg::*;
#(
  parameter int DEPTH = MEM_SKID_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_i,
  input  entry_t                   enq_entry_i,
  input  logic                     clear_i,
  input  logic                     flush_req_i,
  input  logic                     flush_all_i,
  input  logic [MEM_AL_PTR_W-1:0]  flush_head_i,
  input  logic [MEM_AL_PTR_W-1:0]  flush_tail_i,
  input  logic                     out_rdy_i,
  output logic                     out_vld_o,
  output logic                     out_replay_o,
  output logic [MEM_AL_PTR_W-1:0]  out_al_ptr_o,
  output logic [MEM_PAYLOAD_W-1:0] out_payload_o,
  output logic                     in_rdy_o
`ifdef MEM_ISSUE_SKID_PERF_EN
  , output logic [cnt_w(DEPTH)-1:0] kill_cnt_o
`endif
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  entry_t            head;
  logic              head_live;
  logic              pop;

  assign head      = mem_q[rd_q];
  // Flush is checked combinationally on the head so a flushed op never
  // reaches register read, even in the flush cycle itself.
  assign head_live = head.valid &&
                     !in_range(flush_req_i, flush_all_i, flush_head_i, flush_tail_i, head.al_ptr);
  assign out_vld_o = (cnt_q != '0) && !clear_i && head_live;
  // Dead heads drain regardless of downstream readiness.
  assign pop       = (cnt_q != '0) && (!head_live || out_rdy_i);
  assign in_rdy_o  = (cnt_q < CNT_W'(DEPTH)) ||
                     ((cnt_q == CNT_W'(DEPTH)) && out_rdy_i && out_vld_o);

  assign out_replay_o  = head.replay;
  assign out_al_ptr_o  = head.al_ptr;
  assign out_payload_o = head.payload;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i].valid = 1'b0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (flush_req_i) begin
        for (int i = 0; i < DEPTH; i++)
          if (in_range(flush_req_i, flush_all_i, flush_head_i, flush_tail_i, mem_q[i].al_ptr))
            mem_d[i].valid = 1'b0;
      end
      // Vacated slots hold valid=0 so only occupied live entries carry it.
      if (pop) begin
        mem_d[rd_q].valid = 1'b0;
        rd_d              = rd_q + 1'b1;
      end
      if (enq_i) begin
        mem_d[wr_q] = enq_entry_i;
        wr_d        = wr_q + 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(enq_i) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef MEM_ISSUE_SKID_PERF_EN
  always_comb begin
    kill_cnt_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem_q[i].valid && (clear_i ||
          in_range(flush_req_i, flush_all_i, flush_head_i, flush_tail_i, mem_q[i].al_ptr)))
        kill_cnt_o = kill_cnt_o + CNT_W'(1);
  end
`endif

endmodule

// File: rtl/mem_issue_skid_stage.sv
// Memory-pipe issue stage: NUM_LANES independent skid FIFOs with selective flush and replay.
// Latency: 1 cycle from accepted op to out_valid; iq_issue is same-cycle.
// Backpressure: per-lane in_ready, deasserted only when that lane's skid is full.
// Ports: clk, rst (async active-low), bus (slave modport of mem_issue_skid_stage_if).
// Optional: define MEM_ISSUE_SKID_PERF_EN for perf_cnt (per lane: enq, squash, stall).
// Struct-carried widths (AL_PTR_W, PAYLOAD_W) follow mem_issue_skid_pkg.
module mem_issue_skid_stage
  import mem_issue_skid_pkg::*;
#(
  parameter int NUM_LANES  = MEM_NUM_LANES,
  parameter int SKID_DEPTH = MEM_SKID_DEPTH,
  parameter int AL_PTR_W   = MEM_AL_PTR_W,
  parameter int IQ_PTR_W   = MEM_IQ_PTR_W,
  parameter int PAYLOAD_W  = MEM_PAYLOAD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_issue_skid_stage_if.slave   bus
`ifdef MEM_ISSUE_SKID_PERF_EN
  , output logic [NUM_LANES*3*32-1:0] perf_cnt
`endif
);

  // Release pointer is the incoming select index; iq_issue qualifies it.
  assign bus.iq_issue_ptr = bus.in_iq_ptr;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic                 src_vld;
    logic [AL_PTR_W-1:0]  src_al_ptr;
    entry_t               src_entry;
    logic                 src_flushed;
    logic                 lane_in_rdy;
    logic                 lane_enq;

    assign src_vld    = bus.replay ? bus.replay_valid[l] : bus.in_valid[l];
    assign src_al_ptr = bus.replay ? bus.replay_al_ptr[l*AL_PTR_W +: AL_PTR_W]
                                   : bus.in_al_ptr[l*AL_PTR_W +: AL_PTR_W];
    assign src_entry.valid   = 1'b1;
    assign src_entry.replay  = bus.replay;
    assign src_entry.al_ptr  = src_al_ptr;
    assign src_entry.payload = bus.replay ? bus.replay_payload[l*PAYLOAD_W +: PAYLOAD_W]
                                          : bus.in_payload[l*PAYLOAD_W +: PAYLOAD_W];

    // Incoming op is checked against this cycle's flush range so it is never written.
    assign src_flushed = in_range(bus.flush_req, bus.flush_all, bus.flush_head,
                                  bus.flush_tail, src_al_ptr);
    assign lane_enq    = src_vld && lane_in_rdy && !bus.clear && !src_flushed;

    assign bus.in_ready[l] = lane_in_rdy;
    assign bus.iq_issue[l] = lane_enq && !bus.replay;

`ifdef MEM_ISSUE_SKID_PERF_EN
    logic [cnt_w(SKID_DEPTH)-1:0] kill_cnt;
`endif

    mem_issue_skid_fifo #(.DEPTH(SKID_DEPTH)) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .enq_i         (lane_enq),
      .enq_entry_i   (src_entry),
      .clear_i       (bus.clear),
      .flush_req_i   (bus.flush_req),
      .flush_all_i   (bus.flush_all),
      .flush_head_i  (bus.flush_head),
      .flush_tail_i  (bus.flush_tail),
      .out_rdy_i     (bus.out_ready[l]),
      .out_vld_o     (bus.out_valid[l]),
      .out_replay_o  (bus.out_replay[l]),
      .out_al_ptr_o  (bus.out_al_ptr[l*AL_PTR_W +: AL_PTR_W]),
      .out_payload_o (bus.out_payload[l*PAYLOAD_W +: PAYLOAD_W]),
      .in_rdy_o      (lane_in_rdy)
`ifdef MEM_ISSUE_SKID_PERF_EN
      , .kill_cnt_o  (kill_cnt)
`endif
    );

`ifdef MEM_ISSUE_SKID_PERF_EN
    logic [31:0] enq_cnt_q, sq_cnt_q, stall_cnt_q;
    logic [31:0] sq_inc;

    // Squashes: stored live entries killed plus accepted-slot ops dropped by flush/clear.
    assign sq_inc = 32'(kill_cnt) +
                    32'(src_vld && lane_in_rdy && (bus.clear || src_flushed));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        enq_cnt_q   <= '0;
        sq_cnt_q    <= '0;
        stall_cnt_q <= '0;
      end else begin
        enq_cnt_q   <= sat_add32(enq_cnt_q, 32'(lane_enq));
        sq_cnt_q    <= sat_add32(sq_cnt_q, sq_inc);
        stall_cnt_q <= sat_add32(stall_cnt_q, 32'(bus.in_valid[l] && !lane_in_rdy));
      end
    end

    assign perf_cnt[(l*3+0)*32 +: 32] = enq_cnt_q;
    assign perf_cnt[(l*3+1)*32 +: 32] = sq_cnt_q;
    assign perf_cnt[(l*3+2)*32 +: 32] = stall_cnt_q;
`endif
  end

endmodule

// File: tb/tb_mem_issue_skid_stage.sv
// Directed bench for mem_issue_skid_stage: enqueue latency, per-lane backpressure,
// wrap-aware flush, replay, clear and asynchronous reset.
module tb_mem_issue_skid_stage;
  import mem_issue_skid_pkg::*;

  localparam int NL = 2;
  localparam int AW = 6;
  localparam int IW = 5;
  localparam int PW = 96;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_issue_skid_stage_if #(.NUM_LANES(NL), .AL_PTR_W(AW), .IQ_PTR_W(IW), .PAYLOAD_W(PW)) bus ();

`ifdef MEM_ISSUE_SKID_PERF_EN
  logic [NL*3*32-1:0] perf_cnt;
`endif

  mem_issue_skid_stage #(
    .NUM_LANES(NL), .SKID_DEPTH(2), .AL_PTR_W(AW), .IQ_PTR_W(IW), .PAYLOAD_W(PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ISSUE_SKID_PERF_EN
    , .perf_cnt (perf_cnt)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid       = '0;
    bus.in_payload     = '0;
    bus.in_al_ptr      = '0;
    bus.in_iq_ptr      = '0;
    bus.replay         = 1'b0;
    bus.replay_valid   = '0;
    bus.replay_payload = '0;
    bus.replay_al_ptr  = '0;
    bus.clear          = 1'b0;
    bus.flush_req      = 1'b0;
    bus.flush_all      = 1'b0;
    bus.flush_head     = '0;
    bus.flush_tail     = '0;
  endtask

  initial begin
    idle_inputs();
    bus.out_ready = '0;

    // Reset state
    #12;
    check("rst_out_valid",  bus.out_valid,  2'b00);
    check("rst_iq_issue",   bus.iq_issue,   2'b00);
    check("rst_in_ready",   bus.in_ready,   2'b11);
    check("rst_out_replay", bus.out_replay, 2'b00);
    check("rst_out_al",     bus.out_al_ptr, 12'h000);
    check("rst_out_pay0",   bus.out_payload[PW-1:0], 96'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Lane 0 single op: iq_issue same cycle, out_valid next cycle
    bus.out_ready      = 2'b11;
    bus.in_valid       = 2'b01;
    bus.in_al_ptr[5:0] = 6'd5;
    bus.in_iq_ptr[4:0] = 5'd3;
    bus.in_payload[PW-1:0] = 96'hABCD_0000_1234;
    #1;
    check("t1_iq_issue",     bus.iq_issue, 2'b01);
    check("t1_iq_issue_ptr", bus.iq_issue_ptr[4:0], 5'd3);
    check("t1_out_valid_pre", bus.out_valid, 2'b00);
    tick();
    idle_inputs();
    #1;
    check("t1_out_valid",  bus.out_valid, 2'b01);
    check("t1_out_al",     bus.out_al_ptr[5:0], 6'd5);
    check("t1_out_payload", bus.out_payload[PW-1:0], 96'hABCD_0000_1234);
    check("t1_out_replay", bus.out_replay, 2'b00);
    tick();
    check("t1_drained", bus.out_valid, 2'b00);

    // Lane 1 backpressure: two fit, third waits; lane 0 unaffected
    bus.out_ready       = 2'b01;
    bus.in_valid        = 2'b10;
    bus.in_al_ptr[11:6] = 6'd10;
    #1;
    check("t2_ready_a", bus.in_ready, 2'b11);
    tick();
    bus.in_al_ptr[11:6] = 6'd11;
    #1;
    check("t2_ready_b", bus.in_ready, 2'b11);
    tick();
    bus.in_al_ptr[11:6] = 6'd12;
    #1;
    check("t2_full_ready", bus.in_ready, 2'b01);
    check("t2_full_iq",    bus.iq_issue, 2'b00);
    check("t2_head_vld",   bus.out_valid, 2'b10);
    check("t2_head_al",    bus.out_al_ptr[11:6], 6'd10);
    bus.in_valid  = 2'b00;
    bus.out_ready = 2'b11;
    #1;
    check("t2_full_popping_ready", bus.in_ready, 2'b11);
    tick();
    check("t2_second_vld", bus.out_valid, 2'b10);
    check("t2_second_al",  bus.out_al_ptr[11:6], 6'd11);
    tick();
    check("t2_empty", bus.out_valid, 2'b00);

    // Wrap flush [60,2): lane0 {61,1} killed, lane1 {3} survives, incoming 62 dropped
    bus.out_ready       = 2'b00;
    bus.in_valid        = 2'b11;
    bus.in_al_ptr[5:0]  = 6'd61;
    bus.in_al_ptr[11:6] = 6'd3;
    tick();
    bus.in_valid       = 2'b01;
    bus.in_al_ptr[5:0] = 6'd1;
    tick();
    bus.in_valid        = 2'b10;
    bus.in_al_ptr[11:6] = 6'd62;
    bus.flush_req       = 1'b1;
    bus.flush_head      = 6'd60;
    bus.flush_tail      = 6'd2;
    #1;
    check("t3_flush_vld", bus.out_valid, 2'b10);
    check("t3_flush_iq",  bus.iq_issue,  2'b00);
    tick();
    idle_inputs();
    #1;
    check("t3_post_vld",  bus.out_valid, 2'b10);
    check("t3_post_al1",  bus.out_al_ptr[11:6], 6'd3);
    tick();
    check("t3_squash_vld", bus.out_valid, 2'b10);
    tick();
    bus.out_ready = 2'b11;
    tick();
    check("t3_all_drained", bus.out_valid, 2'b00);
    check("t3_ready",       bus.in_ready,  2'b11);

    // head==tail without flush_all is empty; flush_all kills everything
    bus.out_ready      = 2'b00;
    bus.in_valid       = 2'b01;
    bus.in_al_ptr[5:0] = 6'd7;
    tick();
    bus.in_valid   = 2'b00;
    bus.flush_req  = 1'b1;
    bus.flush_head = 6'd7;
    bus.flush_tail = 6'd7;
    #1;
    check("t3_emptyrange_vld", bus.out_valid, 2'b01);
    tick();
    bus.flush_req = 1'b0;
    #1;
    check("t3_emptyrange_kept", bus.out_valid, 2'b01);
    check("t3_emptyrange_al",   bus.out_al_ptr[5:0], 6'd7);
    bus.flush_req = 1'b1;
    bus.flush_all = 1'b1;
    #1;
    check("t3_flushall_vld", bus.out_valid, 2'b00);
    tick();
    idle_inputs();
    #1;
    check("t3_flushall_gone",  bus.out_valid, 2'b00);
    check("t3_flushall_ready", bus.in_ready,  2'b11);

    // Replay: lane 0 from replay_*, in_* ignored, no issue-queue release
    bus.replay              = 1'b1;
    bus.replay_valid        = 2'b01;
    bus.replay_al_ptr[5:0]  = 6'd20;
    bus.replay_payload[PW-1:0] = 96'h5A5A;
    bus.in_valid            = 2'b11;
    bus.in_al_ptr[5:0]      = 6'd33;
    #1;
    check("t4_iq_issue", bus.iq_issue, 2'b00);
    tick();
    idle_inputs();
    #1;
    check("t4_out_vld",    bus.out_valid,  2'b01);
    check("t4_out_replay", bus.out_replay, 2'b01);
    check("t4_out_al",     bus.out_al_ptr[5:0], 6'd20);
    check("t4_out_pay",    bus.out_payload[PW-1:0], 96'h5A5A);
    bus.out_ready = 2'b11;
    tick();
    check("t4_drained", bus.out_valid, 2'b00);

    // clear with both lanes full and new ops offered
    bus.out_ready       = 2'b00;
    bus.in_valid        = 2'b11;
    bus.in_al_ptr[5:0]  = 6'd40;
    bus.in_al_ptr[11:6] = 6'd41;
    tick();
    tick();
    check("t5_full_ready", bus.in_ready, 2'b00);
    bus.clear = 1'b1;
    #1;
    check("t5_clear_iq",  bus.iq_issue,  2'b00);
    check("t5_clear_vld", bus.out_valid, 2'b00);
    tick();
    idle_inputs();
    #1;
    check("t5_after_vld",   bus.out_valid, 2'b00);
    check("t5_after_ready", bus.in_ready,  2'b11);

    // Asynchronous reset mid-stream
    bus.in_valid       = 2'b01;
    bus.in_al_ptr[5:0] = 6'd9;
    tick();
    idle_inputs();
    #1;
    check("t6_pre_vld", bus.out_valid, 2'b01);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_vld",   bus.out_valid, 2'b00);
    check("t6_rst_al",    bus.out_al_ptr, 12'h000);
    check("t6_rst_ready", bus.in_ready, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("t6_post_vld",   bus.out_valid, 2'b00);
    check("t6_post_ready", bus.in_ready,  2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_issue_skid_stage.md
Name: mem_issue_skid_stage

Overview:
Parametrised successor to the memory-pipe issue stage. It sits between the memory scheduler select logic and the memory register-read stage, with NUM_LANES independent lanes. Each lane has a SKID_DEPTH-entry skid FIFO, so per-lane downstream backpressure does not stall the scheduler. It also adds wrap-aware selective flush, replay override and per-lane issue-queue release signalling.

Parameters:
NUM_LANES, 2, number of memory issue lanes.
SKID_DEPTH, 2, entries per lane skid FIFO (power of two, >=2).
AL_PTR_W, 6, active-list pointer width; pointers wrap modulo 2^AL_PTR_W.
IQ_PTR_W, 5, issue-queue index width.
PAYLOAD_W, 96, opaque memory-op payload width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous active-low reset (asserted at 0); deassertion is synchronised externally.
in_valid  in  NUM_LANES  scheduler has selected an op in this lane.
in_payload  in  NUM_LANES*PAYLOAD_W  selected op payload.
in_al_ptr  in  NUM_LANES*AL_PTR_W  active-list pointer of the selected op.
in_iq_ptr  in  NUM_LANES*IQ_PTR_W  issue-queue index of the selected op.
in_ready  out  NUM_LANES  lane can accept this cycle.
replay  in  1  replay mode; replay_* inputs replace in_* in all lanes.
replay_valid  in  NUM_LANES  replay entry valid.
replay_payload  in  NUM_LANES*PAYLOAD_W  replay payload.
replay_al_ptr  in  NUM_LANES*AL_PTR_W  replay active-list pointer.
clear  in  1  pipeline clear; drops all contents.
flush_req  in  1  recovery phase entry (selective flush this cycle).
flush_all  in  1  with flush_req, flush every op.
flush_head  in  AL_PTR_W  flush range head (inclusive).
flush_tail  in  AL_PTR_W  flush range tail (exclusive).
iq_issue  out  NUM_LANES  issue-queue entry is consumed (release request).
iq_issue_ptr  out  NUM_LANES*IQ_PTR_W  index being released.
out_valid  out  NUM_LANES  op available to register-read stage.
out_payload  out  NUM_LANES*PAYLOAD_W  FIFO head payload.
out_al_ptr  out  NUM_LANES*AL_PTR_W  FIFO head active-list pointer.
out_replay  out  NUM_LANES  head entry was enqueued under replay.
out_ready  in  NUM_LANES  downstream accepts head.

Behaviour:
- Reset: all FIFOs empty, pointers and counts 0. out_valid=0, iq_issue=0, in_ready=1 (after reset), out_replay=0, data outputs 0.
- Flush match: in_range(p) is true when flush_req && (flush_all || (head<=tail ? head<=p<tail : p>=head || p<tail)). head==tail && !flush_all is an empty range.
- Lane source: src = replay ? replay_* : in_*. Replay entries carry no issue-queue pointer.
- Enqueue: enq = src_valid && in_ready && !clear && !in_range(src_al_ptr). A flushed or cleared op is never written.
- in_ready = count<SKID_DEPTH || (count==SKID_DEPTH && out_ready && out_valid). Enqueue and dequeue in the same cycle while full is allowed.
- iq_issue = enq && !replay; iq_issue_ptr = in_iq_ptr (combinational, same cycle).
- Dequeue: deq = out_valid && out_ready. out_valid = count!=0 && !clear. Latency from enqueue into an empty FIFO to out_valid is 1 cycle; there is no bypass.
- Selective flush: in any flush_req cycle, every stored entry with in_range(al_ptr) has its valid bit cleared.
  - Invalid entries are squashed as they reach the head: a head entry with valid=0 is popped without asserting out_valid.
  - count counts all entries, including invalid ones.
- clear: next cycle all FIFOs are empty. It overrides enqueue and flush.
- Wrap: read and write pointers are modulo SKID_DEPTH. count has width log2(SKID_DEPTH)+1.
- Simultaneous events: flush and enqueue in the same cycle are evaluated against the incoming pointer. Flush and dequeue of the head in the same cycle: out_valid is already 0 because the flush check is combinational on the head; downstream never sees a flushed op.
- Asynchronous reset mid-operation drops all entries immediately; outputs go to their reset values within the same cycle.

Optional Feature:
MEM_ISSUE_SKID_PERF_EN: adds per-lane 32-bit saturating counters and output port perf_cnt (NUM_LANES*3*32).
- Counters: ops enqueued, ops squashed by flush or clear, and cycles with in_valid && !in_ready.
- Counters are reset asynchronously.
- Without the macro, the port and all counter logic are absent.

Decomposition:
A shared package (mem_issue_skid_pkg) holds:
- the entry struct {valid, replay, al_ptr, payload};
- the flush-range function in_range (shared with other stages);
- SKID_DEPTH/count width helpers.
Sub-module mem_issue_skid_fifo is a one-lane FIFO with per-entry valid kill. It is instantiated NUM_LANES times by generate.

Test Plan:
- Lane 0 enqueue al_ptr=5 with out_ready=1 -> iq_issue[0]=1 same cycle; out_valid[0]=1 next cycle with al_ptr=5.
- out_ready=0 on lane 1, three enqueues with SKID_DEPTH=2 -> in_ready[1]=0 after 2 entries; lane 0 unaffected; raising out_ready drains in order.
- Wrap flush head=60, tail=2, stored al_ptr {61,1,3} -> only 3 remains; head=tail=7 without flush_all -> nothing flushed.
- replay=1 with replay_valid=01 -> lane 0 enqueued with out_replay=1; iq_issue stays 0.
- clear with full FIFOs and concurrent in_valid -> all empty next cycle, no iq_issue.
- rst low mid-stream -> out_valid=0 immediately; after release, FIFOs are empty and in_ready=1.
